multi_channel_timer: RTL and testbench
======================================

Name: multi_channel_timer

Overview:
Parametrised N-channel timer for the test shield, successor to the single-channel elapsed/count-down timer. Each channel independently measures elapsed time, performs a one-shot delay, or generates periodic expiry pulses. Counter width is configurable, and each channel has its own synchronous clear. It sits behind the register/control interface, where it serves delay generation and pulse-width measurement for peripheral tests. One tick is one `clk` period (10 ns).

Parameters:
WIDTH, 64, counter width in bits (legal range 8..64)
CHANNELS, 4, number of independent timer channels (legal range 1..16)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  global reset, synchronous, active-high; acts as `ch_rst` asserted on every channel
ch_rst  input  CHANNELS  per-channel synchronous clear/load, active-high
enable  input  CHANNELS  per-channel count enable
mode  input  2*CHANNELS  per-channel mode; channel i uses bits [2i+1:2i]
count_once  input  CHANNELS  MODE_TIMER only: count only the first enable pulse after a clear
load_value  input  WIDTH*CHANNELS  per-channel count-down/reload value; slice [WIDTH*(i+1)-1:WIDTH*i]
counter  output  WIDTH*CHANNELS  per-channel current count, registered
delay_pending  output  CHANNELS  combinational; 1 while a count-down is still in progress
expired  output  CHANNELS  registered; 1-cycle pulse when a count-down reaches 0
overflow  output  CHANNELS  registered, sticky; MODE_TIMER counter saturated

Behaviour:
- Modes: 00 MODE_TIMER, 01 MODE_ONE_SHOT, 10 MODE_PERIODIC, 11 reserved. Reserved mode holds counter and drives all flags 0.
- Clear (`rst` or `ch_rst[i]` sampled high):
  - MODE_TIMER: counter <= 0, counting_enabled <= 1.
  - Count-down modes: counter <= `load_value`.
  - All modes: expired <= 0, overflow <= 0.
  - Clear has priority over every other event in the same cycle.
- Reset values of the other registers: enable_prev <= 0. Mode is sampled every cycle; changing mode without a clear is undefined and need not be handled.
- MODE_TIMER:
  - If enable=1 and counting_enabled=1: counter +1.
  - At all-ones, the counter holds its value and overflow <= 1, in the same cycle as the blocked increment.
  - Falling edge of enable (enable=0, enable_prev=1) with count_once=1: counting_enabled <= 0, until the next clear.
  - delay_pending = 0 and expired = 0 in this mode.
- MODE_ONE_SHOT:
  - If enable=1 and counter>0: counter -1.
  - expired pulses for 1 cycle in the cycle after counter transitions 1 -> 0.
  - delay_pending = (counter != 0).
  - load_value=0 at clear: delay_pending 0 immediately, no expired pulse.
- MODE_PERIODIC:
  - If enable=1 and counter>1: counter -1.
  - If enable=1 and counter==1: counter <= `load_value` (sampled that cycle) and expired pulses 1 cycle.
  - Period is `load_value` enabled ticks.
  - If counter==0 (load_value 0): channel stays idle with no pulses.
  - delay_pending = (counter != 0).
  - A `load_value` change takes effect at the next reload or clear.
- enable low freezes the counter in every mode; expired never pulses while enable is low.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Latency: counter and expired/overflow update 1 cycle after the sampled inputs; delay_pending follows counter combinationally.

Decomposition:
- Package `timer_pkg`: mode localparams MODE_TIMER, MODE_ONE_SHOT, MODE_PERIODIC, MODE_RESERVED (2-bit).
- Sub-module `timer_channel` (parameter WIDTH): one channel's counter, counting_enabled, enable_prev, expired, overflow.
- Top-level `multi_channel_timer`: generate loop instantiating CHANNELS `timer_channel`s, OR-ing `rst` into each `ch_rst`, and slicing the packed buses.

Test Plan:
- Ch0 MODE_TIMER, clear, enable high 100 cycles then low -> counter0=100, held; no flags set.
- Ch0 MODE_TIMER, count_once=1, enable pulses 10 then 20 cycles -> counter0=10 after the second pulse; clear then 5-cycle pulse -> 5.
- WIDTH=8, MODE_TIMER, enable 300 cycles -> counter=255 from cycle 255; overflow=1 and sticky until ch_rst.
- Ch1 MODE_ONE_SHOT, load_value=50, clear, enable held -> delay_pending falls after exactly 50 enabled cycles; single expired pulse; counter stays 0.
- Ch2 MODE_PERIODIC, load_value=4, enable held 20 cycles -> expired pulses every 4 cycles (5 pulses); counter sequence 4,3,2,1,4,…. Concurrently ch3 ONE_SHOT with load_value=0 -> delay_pending=0, no expired pulse.
- Mid-operation: ch1 ONE_SHOT at counter=20, assert ch_rst together with enable -> counter=load_value next cycle, no decrement, no expired pulse; channels 0/2 unaffected.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer.
// Mode encodings used by every channel.
package timer_pkg;

    localparam logic [1:0] MODE_TIMER    = 2'b00;
    localparam logic [1:0] MODE_ONE_SHOT = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: elapsed counter, one-shot delay or periodic reload.
// Flags are suppressed in the reserved mode.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic             i_count_once,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_counter,
    output logic             o_delay_pending,
    output logic             o_expired,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_counter;
    logic             r_counting_en;
    logic             r_enable_prev;
    logic             r_expired;
    logic             r_overflow;

    logic w_nonzero;
    logic w_is_one;
    logic w_at_max;
    logic w_countdown;

    assign w_nonzero   = (r_counter != '0);
    assign w_is_one    = (r_counter == WIDTH'(1));
    assign w_at_max    = (r_counter == {WIDTH{1'b1}});
    assign w_countdown = (i_mode == MODE_ONE_SHOT) || (i_mode == MODE_PERIODIC);

    always_ff @(posedge clk) begin
        r_expired <= 1'b0;
        if (i_clr) begin
            r_overflow    <= 1'b0;
            r_enable_prev <= 1'b0;
            r_counting_en <= 1'b1;
            case (i_mode)
                MODE_TIMER:    r_counter <= '0;
                MODE_ONE_SHOT: r_counter <= i_load_value;
                MODE_PERIODIC: r_counter <= i_load_value;
                default:       r_counter <= r_counter;
            endcase
        end else begin
            r_enable_prev <= i_enable;
            case (i_mode)
                MODE_TIMER: begin
                    if (i_enable && r_counting_en) begin
                        if (w_at_max) r_overflow <= 1'b1;
                        else          r_counter  <= r_counter + WIDTH'(1);
                    end
                    // count_once: latch off after the first enable pulse ends
                    if (!i_enable && r_enable_prev && i_count_once)
                        r_counting_en <= 1'b0;
                end
                MODE_ONE_SHOT: begin
                    if (i_enable && w_nonzero) begin
                        r_counter <= r_counter - WIDTH'(1);
                        r_expired <= w_is_one;
                    end
                end
                MODE_PERIODIC: begin
                    if (i_enable && w_is_one) begin
                        r_counter <= i_load_value;
                        r_expired <= 1'b1;
                    end else if (i_enable && w_nonzero) begin
                        r_counter <= r_counter - WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_counter       = r_counter;
    assign o_delay_pending = w_countdown && w_nonzero;
    assign o_expired       = w_countdown && r_expired;
    assign o_overflow      = (i_mode != MODE_RESERVED) && r_overflow;

endmodule

// File: rtl/multi_channel_timer.sv
// N independent timer channels sharing one clock and a global clear.
// Packed buses are sliced per channel; rst acts as every channel's clear.
module multi_channel_timer #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ch_rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       count_once,
    input  logic [WIDTH*CHANNELS-1:0] load_value,
    output logic [WIDTH*CHANNELS-1:0] counter,
    output logic [CHANNELS-1:0]       delay_pending,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       overflow
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic w_clr;
        assign w_clr = rst | ch_rst[g];

        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk             (clk),
            .i_clr           (w_clr),
            .i_enable        (enable[g]),
            .i_mode          (mode[2*g +: 2]),
            .i_count_once    (count_once[g]),
            .i_load_value    (load_value[WIDTH*g +: WIDTH]),
            .o_counter       (counter[WIDTH*g +: WIDTH]),
            .o_delay_pending (delay_pending[g]),
            .o_expired       (expired[g]),
            .o_overflow      (overflow[g])
        );
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_multi_channel_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   a_chrst, a_en, a_once;
    logic [7:0]   a_mode;
    logic [255:0] a_ld;
    logic [255:0] a_cnt;
    logic [3:0]   a_dp, a_ex, a_ov;

    logic [1:0]   b_chrst, b_en, b_once;
    logic [3:0]   b_mode;
    logic [15:0]  b_ld;
    logic [15:0]  b_cnt;
    logic [1:0]   b_dp, b_ex, b_ov;

    multi_channel_timer u_dut (
        .clk           (clk),
        .rst           (rst),
        .ch_rst        (a_chrst),
        .enable        (a_en),
        .mode          (a_mode),
        .count_once    (a_once),
        .load_value    (a_ld),
        .counter       (a_cnt),
        .delay_pending (a_dp),
        .expired       (a_ex),
        .overflow      (a_ov)
    );

    multi_channel_timer #(
        .WIDTH    (8),
        .CHANNELS (2)
    ) u_dut8 (
        .clk           (clk),
        .rst           (rst),
        .ch_rst        (b_chrst),
        .enable        (b_en),
        .mode          (b_mode),
        .count_once    (b_once),
        .load_value    (b_ld),
        .counter       (b_cnt),
        .delay_pending (b_dp),
        .expired       (b_ex),
        .overflow      (b_ov)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp,
                         $time);
        end
    endtask

    // Model state per [dut][channel]
    logic [63:0] m_cnt  [2][4];
    bit          m_ce   [2][4];
    bit          m_prev [2][4];
    bit          m_exp  [2][4];
    bit          m_ovf  [2][4];

    task automatic model_chan(input int d, input int i, input bit clr,
                              input bit en, input bit once,
                              input logic [1:0] md, input logic [63:0] ld,
                              input int w);
        logic [63:0] top;
        top = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        m_exp[d][i] = 1'b0;
        if (clr) begin
            m_ovf[d][i]  = 1'b0;
            m_prev[d][i] = 1'b0;
            m_ce[d][i]   = 1'b1;
            if (md == 2'd0) m_cnt[d][i] = 64'd0;
            else if (md != 2'd3) m_cnt[d][i] = ld & top;
            return;
        end
        if (md == 2'd0) begin
            if (en && m_ce[d][i]) begin
                if (m_cnt[d][i] == top) m_ovf[d][i] = 1'b1;
                else m_cnt[d][i] = m_cnt[d][i] + 64'd1;
            end
            if (!en && m_prev[d][i] && once) m_ce[d][i] = 1'b0;
        end else if (md == 2'd1) begin
            if (en && m_cnt[d][i] != 0) begin
                m_cnt[d][i] = m_cnt[d][i] - 64'd1;
                m_exp[d][i] = (m_cnt[d][i] == 0);
            end
        end else if (md == 2'd2) begin
            if (en && m_cnt[d][i] == 1) begin
                m_cnt[d][i] = ld & top;
                m_exp[d][i] = 1'b1;
            end else if (en && m_cnt[d][i] > 1) begin
                m_cnt[d][i] = m_cnt[d][i] - 64'd1;
            end
        end
        m_prev[d][i] = en;
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++)
            model_chan(0, i, rst | a_chrst[i], a_en[i], a_once[i],
                       a_mode[2*i +: 2], a_ld[64*i +: 64], 64);
        for (int i = 0; i < 2; i++)
            model_chan(1, i, rst | b_chrst[i], b_en[i], b_once[i],
                       b_mode[2*i +: 2], {56'd0, b_ld[8*i +: 8]}, 8);
    endtask

    function automatic bit cd(input logic [1:0] md);
        return (md == 2'd1) || (md == 2'd2);
    endfunction

    task automatic check_all();
        logic [1:0] md;
        for (int i = 0; i < 4; i++) begin
            md = a_mode[2*i +: 2];
            chk($sformatf("a%0d_cnt", i), a_cnt[64*i +: 64], m_cnt[0][i]);
            chk($sformatf("a%0d_dp", i), a_dp[i],
                cd(md) && m_cnt[0][i] != 0);
            chk($sformatf("a%0d_ex", i), a_ex[i], cd(md) && m_exp[0][i]);
            chk($sformatf("a%0d_ov", i), a_ov[i], md != 3 && m_ovf[0][i]);
        end
        for (int i = 0; i < 2; i++) begin
            md = b_mode[2*i +: 2];
            chk($sformatf("b%0d_cnt", i), b_cnt[8*i +: 8], m_cnt[1][i]);
            chk($sformatf("b%0d_dp", i), b_dp[i],
                cd(md) && m_cnt[1][i] != 0);
            chk($sformatf("b%0d_ex", i), b_ex[i], cd(md) && m_exp[1][i]);
            chk($sformatf("b%0d_ov", i), b_ov[i], md != 3 && m_ovf[1][i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int n, pulses, other;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                m_cnt[d][i] = 0; m_ce[d][i] = 0; m_prev[d][i] = 0;
                m_exp[d][i] = 0; m_ovf[d][i] = 0;
            end
        rst = 1'b1;
        a_chrst = '0; a_en = '0; a_once = '0; a_ld = '0;
        a_mode = {2'b01, 2'b10, 2'b01, 2'b00};
        a_ld[127:64]  = 64'd50;
        a_ld[191:128] = 64'd4;
        b_chrst = '0; b_en = '0; b_once = '0; b_ld = '0;
        b_mode = 4'b0000;
        #2;
        tick();
        chk("rst_cnt0", a_cnt[63:0], 0);
        chk("rst_cnt1", a_cnt[127:64], 50);
        chk("rst_dp", a_dp, 4'b0110);
        chk("rst_flags", {a_ex, a_ov, b_ex, b_ov}, 0);
        rst = 1'b0;

        // Elapsed timer
        a_en[0] = 1'b1;
        ticks(100);
        a_en[0] = 1'b0;
        ticks(5);
        chk("t1_cnt", a_cnt[63:0], 100);
        chk("t1_flags", {a_ov[0], a_ex[0], a_dp[0]}, 0);

        // count_once
        a_once[0] = 1'b1;
        a_chrst[0] = 1'b1; tick(); a_chrst[0] = 1'b0;
        a_en[0] = 1'b1; ticks(10);
        a_en[0] = 1'b0; ticks(3);
        a_en[0] = 1'b1; ticks(20);
        a_en[0] = 1'b0; ticks(3);
        chk("t2_once", a_cnt[63:0], 10);
        a_chrst[0] = 1'b1; tick(); a_chrst[0] = 1'b0;
        a_en[0] = 1'b1; ticks(5);
        a_en[0] = 1'b0; ticks(3);
        chk("t2_reclr", a_cnt[63:0], 5);
        a_once[0] = 1'b0;

        // 8-bit saturation
        b_chrst[0] = 1'b1; tick(); b_chrst[0] = 1'b0;
        b_en[0] = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == 255) begin
                chk("t3_cnt255", b_cnt[7:0], 255);
                chk("t3_ov_early", b_ov[0], 0);
            end
            if (c == 256) chk("t3_ov_set", b_ov[0], 1);
        end
        b_en[0] = 1'b0; ticks(5);
        chk("t3_hold", b_cnt[7:0], 255);
        chk("t3_sticky", b_ov[0], 1);
        b_chrst[0] = 1'b1; tick(); b_chrst[0] = 1'b0;
        chk("t3_clr_ov", b_ov[0], 0);
        chk("t3_clr_cnt", b_cnt[7:0], 0);

        // One-shot delay of 50
        a_chrst[1] = 1'b1; tick(); a_chrst[1] = 1'b0;
        a_en[1] = 1'b1;
        n = 0; pulses = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            n++;
            pulses += a_ex[1];
            if (!a_dp[1]) break;
        end
        chk("t4_len", n, 50);
        ticks(1); pulses += a_ex[1];
        for (int c = 0; c < 9; c++) begin tick(); pulses += a_ex[1]; end
        chk("t4_pulses", pulses, 1);
        chk("t4_cnt0", a_cnt[127:64], 0);

        // Periodic 4 plus one-shot with zero load
        a_chrst[3:2] = 2'b11; tick(); a_chrst[3:2] = 2'b00;
        a_en[3:2] = 2'b11;
        pulses = 0; other = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t5_seq", a_cnt[191:128], (k % 4 == 0) ? 4 : 4 - (k % 4));
            pulses += a_ex[2];
            other  += a_ex[3] + a_dp[3];
        end
        chk("t5_pulses", pulses, 5);
        chk("t5_ch3", other, 0);

        // Clear beats a concurrent decrement
        a_en[0] = 1'b1;
        a_chrst[1] = 1'b1; tick(); a_chrst[1] = 1'b0;
        a_en[1] = 1'b1; ticks(30);
        chk("t6_mid", a_cnt[127:64], 20);
        a_chrst[1] = 1'b1; tick(); a_chrst[1] = 1'b0;
        chk("t6_reload", a_cnt[127:64], 50);
        chk("t6_noexp", a_ex[1], 0);
        ticks(2);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                a_chrst[i] = ($urandom_range(0, 15) == 0);
                if (a_chrst[i]) a_mode[2*i +: 2] = 2'($urandom_range(0, 3));
                a_en[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) a_once[i] = ~a_once[i];
                if ($urandom_range(0, 7) == 0)
                    a_ld[64*i +: 64] = 64'($urandom_range(0, 9));
            end
            for (int i = 0; i < 2; i++) begin
                b_chrst[i] = ($urandom_range(0, 63) == 0);
                if (b_chrst[i]) b_mode[2*i +: 2] = 2'($urandom_range(0, 3));
                b_en[i] = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 19) == 0) b_once[i] = ~b_once[i];
                if ($urandom_range(0, 7) == 0)
                    b_ld[8*i +: 8] = 8'($urandom_range(0, 12));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
